tff_bank: RTL and testbench
===========================

// Module: tff_bank
// PURPOSE
//  Parametrised bank of WIDTH T flip-flops sharing one clock and one async active-high reset.
//  - Per-bit independent toggle mode.
//  - Chained synchronous T-FF counter mode with wrap (carry) pulse.
//  - Parallel load and synchronous clear.
//  - Per-bit change flags and a saturating toggle-event counter for debug/observability.
//  Next generation of the single-bit async-reset T flip-flop: drop-in building block for dividers/counters.
// PARAMETERS
//  WIDTH     8   number of T flip-flops (>=1)
//  RESET_VAL 0   value of q after reset (WIDTH bits)
//  CNT_W     8   width of toggle-event counter (>=2)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high reset
//  en         in   1       operation enable; en=0 holds q (mode ignored)
//  mode       in   2       00 TOGGLE, 01 COUNT, 10 LOAD, 11 CLEAR
//  t          in   WIDTH   per-bit toggle requests (TOGGLE mode only)
//  load_val   in   WIDTH   value loaded in LOAD mode
//  q          out  WIDTH   flip-flop outputs
//  chg        out  WIDTH   bits of q that changed on the last clock edge
//  carry      out  1       1-cycle pulse: COUNT mode wrapped all-ones -> zero
//  tog_cnt    out  CNT_W   saturating count of edges where q changed
// BEHAVIOUR
//  Reset (async, immediate, overrides everything):
//  - q=RESET_VAL, chg=0, carry=0, tog_cnt=0.
//  - Release takes effect on the first rising clk edge with reset=0.
//  Per rising edge, reset=0, en=1 (q_n = next q):
//  - TOGGLE: q_n[i] = q[i] ^ t[i]. t=0 holds that bit.
//  - COUNT: bit i toggles iff all bits below i are 1 (bit 0 always toggles).
//    Equivalent to q_n = q+1 mod 2^WIDTH; t is ignored.
//    carry=1 for exactly the cycle after the edge where q was all ones; 0 otherwise.
//  - LOAD: q_n = load_val.
//  - CLEAR: q_n = 0; RESET_VAL does not apply.
//  - carry is 0 in every mode except COUNT wrap.
//  When en=0: q holds, chg=0, carry=0, tog_cnt holds.
//  Registered outputs:
//  - chg = q ^ q_n, registered.
//  - tog_cnt increments by 1 when chg != 0; saturates at 2^CNT_W-1, never wraps.
//  - Outputs are valid one edge after the inputs that caused them.
//  - No combinational path from inputs to outputs.
//  Boundaries:
//  - LOAD of a value equal to q -> chg=0, tog_cnt unchanged.
//  - COUNT with WIDTH=1 -> toggles each edge, carry on each 1->0.
//  - Reset mid-count: q jumps to RESET_VAL without waiting for clk; no carry emitted.
//  - Mode change between edges: only the mode sampled at the edge is used; no state carried between modes.
//  - X/Z on t outside TOGGLE mode must not affect q.
// TESTING (WIDTH=4, RESET_VAL=4'b0000, CNT_W=3 unless noted)
//  1 reset=1 at t=0, release at 100ns, en=1, mode=00, t=4'b0001, 30ns half-period
//    -> q[0] toggles every edge (0,1,0,1...), q[3:1]=0, chg=4'b0001 each cycle.
//  2 mode=01 from q=0 for 16 edges
//    -> q counts 0..15 then 0; carry=1 only in the cycle q returns to 0.
//    -> tog_cnt saturates at 7 after the 7th change.
//  3 mode=10, load_val=4'hA -> q=4'hA, chg=4'hA;
//    hold load_val=4'hA another edge -> chg=0, tog_cnt unchanged.
//  4 q=4'hF in COUNT, assert reset 5ns after an edge
//    -> q=0 immediately (before next edge); carry=0; tog_cnt=0.
//  5 en=0 with mode=01 for 3 edges -> q, tog_cnt unchanged; chg=0, carry=0.
//    Then mode=11 with en=1 -> q=0.
//  6 RESET_VAL=4'b0101: reset -> q=4'b0101; mode=11 -> q=0.

Source files
------------

// File: rtl/tff_bank_if.sv
// Handshake-free control/status bundle for tff_bank: the driver owns en/mode/t/load_val,
// the bank owns the registered status outputs.
interface tff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] chg;
    logic             carry;
    logic [CNT_W-1:0] tog_cnt;

    modport master (
        output en, mode, t, load_val,
        input  q, chg, carry, tog_cnt
    );

    modport slave (
        input  en, mode, t, load_val,
        output q, chg, carry, tog_cnt
    );
endinterface

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops with toggle / ripple-count / load / clear modes,
// plus registered change flags, wrap pulse and a saturating change counter.

// One T flip-flop; chg records whether this bit toggled on the last edge.
module tff_bank_cell #(
    parameter logic RST = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tgl,
    output logic q,
    output logic chg
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q   <= RST;
            chg <= 1'b0;
        end else begin
            q   <= q ^ tgl;
            chg <= tgl;
        end
    end
endmodule

module tff_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input logic   clk,
    input logic   reset,
    tff_bank_if.slave bus
);
    localparam logic [1:0]       M_TOGGLE = 2'b00;
    localparam logic [1:0]       M_COUNT  = 2'b01;
    localparam logic [1:0]       M_LOAD   = 2'b10;
    localparam logic [1:0]       M_CLEAR  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] tgl;
    logic [WIDTH:0]   ones_below;
    logic             wrap;
    logic             carry;
    logic [CNT_W-1:0] tog_cnt;

    // ones_below[i] = all bits below i are set; ones_below[WIDTH] flags all-ones
    assign ones_below[0] = 1'b1;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign ones_below[i+1] = ones_below[i] & q[i];

            tff_bank_cell #(
                .RST (RESET_VAL[i])
            ) u_cell (
                .clk   (clk),
                .reset (reset),
                .tgl   (tgl[i]),
                .q     (q[i]),
                .chg   (chg[i])
            );
        end
    endgenerate

    // Every mode is expressed as a toggle mask so the cells stay pure T flops;
    // t is only looked at in TOGGLE mode, keeping X/Z on it out of q elsewhere.
    always_comb begin
        tgl  = '0;
        wrap = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                M_TOGGLE: tgl = bus.t;
                M_COUNT: begin
                    tgl  = ones_below[WIDTH-1:0];
                    wrap = ones_below[WIDTH];
                end
                M_LOAD:   tgl = q ^ bus.load_val;
                M_CLEAR:  tgl = q;
                default:  tgl = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry   <= 1'b0;
            tog_cnt <= '0;
        end else begin
            carry <= wrap;
            if ((|tgl) && (tog_cnt != CNT_MAX))
                tog_cnt <= tog_cnt + CNT_ONE;
        end
    end

    assign bus.q       = q;
    assign bus.chg     = chg;
    assign bus.carry   = carry;
    assign bus.tog_cnt = tog_cnt;
endmodule

// File: tb/tb_tff_bank.sv
// Directed + random checks of tff_bank against an arithmetic reference model;
// two instances share stimulus, one with RESET_VAL=0 and one with RESET_VAL=4'b0101.
module tb_tff_bank;
    localparam int W = 4;
    localparam int C = 3;
    localparam logic [W-1:0] RV [2] = '{4'b0000, 4'b0101};

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    tff_bank_if #(.WIDTH(W), .CNT_W(C)) b0 ();
    tff_bank_if #(.WIDTH(W), .CNT_W(C)) b1 ();

    assign b1.en       = b0.en;
    assign b1.mode     = b0.mode;
    assign b1.t        = b0.t;
    assign b1.load_val = b0.load_val;

    tff_bank #(.WIDTH(W), .RESET_VAL(4'b0000), .CNT_W(C)) dut0 (
        .clk (clk), .reset (reset), .bus (b0)
    );
    tff_bank #(.WIDTH(W), .RESET_VAL(4'b0101), .CNT_W(C)) dut1 (
        .clk (clk), .reset (reset), .bus (b1)
    );

    initial clk = 1'b0;
    always #30 clk = ~clk;

    int m_q     [2];
    int m_chg   [2];
    int m_carry [2];
    int m_cnt   [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q[k]     = int'(RV[k]);
            m_chg[k]   = 0;
            m_carry[k] = 0;
            m_cnt[k]   = 0;
        end
    endtask

    // Next state from the mode rules with plain integer arithmetic.
    task automatic model_edge();
        int nq;
        if (reset) return;
        for (int k = 0; k < 2; k++) begin
            nq         = m_q[k];
            m_carry[k] = 0;
            if (b0.en) begin
                case (int'(b0.mode))
                    0: nq = m_q[k] ^ int'(b0.t);
                    1: begin
                        nq         = (m_q[k] + 1) % 16;
                        m_carry[k] = (m_q[k] == 15) ? 1 : 0;
                    end
                    2: nq = int'(b0.load_val);
                    default: nq = 0;
                endcase
            end
            m_chg[k] = m_q[k] ^ nq;
            if (m_chg[k] != 0 && m_cnt[k] < 7) m_cnt[k]++;
            m_q[k] = nq;
        end
    endtask

    task automatic check_all(input string tag);
        checks++;
        assert (int'(b0.q) === m_q[0]) else begin
            errors++; $error("FAIL %s q0 got %0h exp %0h", tag, b0.q, m_q[0]);
        end
        checks++;
        assert (int'(b1.q) === m_q[1]) else begin
            errors++; $error("FAIL %s q1 got %0h exp %0h", tag, b1.q, m_q[1]);
        end
        checks++;
        assert (int'(b0.chg) === m_chg[0]) else begin
            errors++; $error("FAIL %s chg0 got %0h exp %0h", tag, b0.chg, m_chg[0]);
        end
        checks++;
        assert (int'(b1.chg) === m_chg[1]) else begin
            errors++; $error("FAIL %s chg1 got %0h exp %0h", tag, b1.chg, m_chg[1]);
        end
        checks++;
        assert (int'(b0.carry) === m_carry[0]) else begin
            errors++; $error("FAIL %s carry0 got %0d exp %0d", tag, b0.carry, m_carry[0]);
        end
        checks++;
        assert (int'(b1.carry) === m_carry[1]) else begin
            errors++; $error("FAIL %s carry1 got %0d exp %0d", tag, b1.carry, m_carry[1]);
        end
        checks++;
        assert (int'(b0.tog_cnt) === m_cnt[0]) else begin
            errors++; $error("FAIL %s cnt0 got %0d exp %0d", tag, b0.tog_cnt, m_cnt[0]);
        end
        checks++;
        assert (int'(b1.tog_cnt) === m_cnt[1]) else begin
            errors++; $error("FAIL %s cnt1 got %0d exp %0d", tag, b1.tog_cnt, m_cnt[1]);
        end
    endtask

    // One rising edge: model follows the inputs held across it, outputs sampled 1ns later.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Reset pulse landing 5ns after an edge; q must jump before the next edge.
    task automatic mid_reset(input string tag);
        #4;
        reset = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        b0.en       = 1'b1;
        b0.mode     = 2'b00;
        b0.t        = 4'b0001;
        b0.load_val = 4'h0;
        model_reset();

        #35;
        check_all("reset");
        #65;
        reset = 1'b0;

        // toggle bit 0 only
        for (int i = 0; i < 6; i++) cycle("toggle");

        // clear then count through a full wrap and on into saturation
        b0.mode = 2'b11;
        cycle("clr");
        b0.mode = 2'b01;
        b0.t    = 4'bxz10;
        for (int i = 0; i < 18; i++) cycle("count");

        // load A, then reload the same value
        b0.mode     = 2'b10;
        b0.load_val = 4'hA;
        cycle("load");
        cycle("reload");

        // load F, switch to count, reset mid-cycle before the wrap edge
        b0.load_val = 4'hF;
        cycle("loadF");
        b0.mode = 2'b01;
        mid_reset("rst_mid");
        cycle("post_rst");

        // hold with en=0, then clear
        b0.en = 1'b0;
        for (int i = 0; i < 3; i++) cycle("hold");
        b0.en   = 1'b1;
        b0.mode = 2'b11;
        cycle("clr2");

        // random mix of modes, enables and occasional async resets
        for (int i = 0; i < 400; i++) begin
            b0.en       = ($urandom_range(0, 7) != 0);
            b0.mode     = 2'($urandom_range(0, 3));
            b0.load_val = 4'($urandom);
            if (b0.mode != 2'b00 && $urandom_range(0, 1) == 1)
                b0.t = 4'bxz10;
            else
                b0.t = 4'($urandom);
            cycle("rand");
            if ($urandom_range(0, 39) == 0) mid_reset("rand_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
